dcache: RTL and testbench
=========================

DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter NUM_LINES, default 32, number of direct-mapped lines; power of two, 2..256.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-low reset.
REQ-004 read_2DC  in  1  MEM stage load request.
REQ-005 write_2DC  in  1  MEM stage store request; never asserted together with read_2DC.
REQ-006 data_address_2DC  in  32  byte address of the access.
REQ-007 data_write_2DC  in  32  store data, right-aligned.
REQ-008 data_write_size_2DC  in  2  bytes to store: 1, 2, 3; 0 means 4.
REQ-009 flush_2DC  in  1  syscall request: write back all dirty lines, then invalidate all lines.
REQ-010 data_read_fDC  out  32  load data, full aligned word.
REQ-011 data_valid_fDC  out  1  access complete this cycle; pipeline stalls while a request is present and this is low.
REQ-012 flush_done  out  1  one-cycle pulse when a flush completes.
REQ-013 data_address_2DM  out  32  block address, bits [4:0] always zero.
REQ-014 dBlkRead / dBlkWrite  out  1 each  block refill / writeback requests.
REQ-015 block_write_2DM  out  256  victim line data.
REQ-016 block_read_fDM  in  256  refill line data.
REQ-017 block_read_fDM_valid / block_write_fDM_valid  in  1 each  block transfer completion.

Function
REQ-018 Address split: offset [4:0], word select [4:2], index [4+log2(NUM_LINES):5], tag = remaining upper bits.
REQ-019 Line layout: word w occupies bits [32w+31:32w] of a 256-bit block, in both directions.
REQ-020 Hit = request present, line valid, tag equal, FSM in IDLE; on a hit, data_valid_fDC is high in the same cycle (combinational), with zero-cycle load latency.
REQ-021 Store hit: write bytes addr[1:0]..addr[1:0]+N-1 of the selected word, big-endian (byte 0 = bits [31:24]), from the low N bytes of data_write_2DC, MSB first; set dirty; takes effect at the next edge. Stores that cross a word boundary are undefined.
REQ-022 FSM states: IDLE, WB, REFILL, FL_SCAN, FL_WB, FL_DONE.
REQ-023 IDLE miss with dirty victim -> WB; with clean or invalid victim -> REFILL.
REQ-024 WB: dBlkWrite=1, address={victim tag, index, 5'b0}, block_write_2DM=victim line, all held stable; on block_write_fDM_valid -> REFILL, victim dirty cleared.
REQ-025 REFILL: dBlkRead=1, address={req tag, index, 5'b0}, held; on block_read_fDM_valid, the line is written with tag, valid=1, dirty=0 -> IDLE; the request then hits on the following cycle (a store merges and sets dirty).
REQ-026 dBlkRead and dBlkWrite are never high together and are low in IDLE.
REQ-027 flush_2DC in IDLE with no pending miss -> FL_SCAN with index counter 0; flush takes priority over a simultaneous read or write, which is serviced after FL_DONE.
REQ-028 FL_SCAN: a dirty line -> FL_WB (same handshake as WB, own tag/index); a clean line -> invalidate and increment; after index NUM_LINES-1 -> FL_DONE.
REQ-029 FL_WB: on block_write_fDM_valid, clear valid/dirty; last index -> FL_DONE, else increment and return to FL_SCAN.
REQ-030 FL_DONE: flush_done=1 for one cycle, data_valid_fDC=0 -> IDLE.
REQ-031 Valid inputs may arrive in the first cycle a request is raised; both are ignored in any state that does not await them.
REQ-032 data_valid_fDC=0 whenever the FSM is not in IDLE or there is no request.

Reset
REQ-033 RESET low at an edge: FSM -> IDLE; all valid and dirty bits -> 0; flush counter -> 0. Data and tag arrays are not cleared.
REQ-034 During and after reset: dBlkRead=0, dBlkWrite=0, data_valid_fDC=0, flush_done=0, data_address_2DM=0, data_read_fDC=0.
REQ-035 Reset mid-WB/REFILL/flush abandons the transfer without any line update; a late block valid afterwards is ignored.

Structure
REQ-036 Shared package cache_pkg holds: the FSM state enum, LINE_BITS=256, WORDS_PER_LINE=8, OFFSET_BITS=5, and the byte-merge function.
REQ-037 One sub-module, dcache_array, holds the tag/data/valid/dirty storage: one combinational read port and one write port with per-byte enables.

Verification
REQ-038 After reset, load 0x00001000 -> REFILL at 0x00001000; supply block word0=0xDEADBEEF with valid after 3 cycles -> data_read_fDC=0xDEADBEEF, valid on the next cycle.
REQ-039 Store size 1, addr 0x00001001, data 0x000000AA -> later load of 0x00001000 returns 0xDEAABEEF, with no block traffic.
REQ-040 Load 0x00002000 (same index, dirty line) -> dBlkWrite at 0x00001000 carrying word0 0xDEAABEEF, then dBlkRead at 0x00002000.
REQ-041 Two dirty lines at indices 0 and 5, then flush_2DC -> exactly two dBlkWrites in index order, then a single flush_done pulse; the next load misses.
REQ-042 RESET low during REFILL while block valid is withheld -> dBlkRead=0 on the next cycle; a subsequent load to the same address misses again.
REQ-043 Store size 0, addr 0x00001004, data 0x12345678 on a hit -> load returns 0x12345678; adjacent words are unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache: line geometry, FSM states
// and the big-endian store merge helpers.
package cache_pkg;

  localparam int LINE_BITS      = 256;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_BITS    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_REFILL,
    ST_FL_SCAN,
    ST_FL_WB,
    ST_FL_DONE
  } state_t;

  function automatic logic [2:0] store_bytes(input logic [1:0] size);
    return (size == 2'd0) ? 3'd4 : {1'b0, size};
  endfunction

  // Lanes between the last stored byte and the low end of the word.
  function automatic logic [1:0] store_shift(input logic [1:0] off, input logic [1:0] size);
    logic [2:0] used;
    logic [2:0] diff;
    used = {1'b0, off} + store_bytes(size);
    diff = (used > 3'd4) ? 3'd0 : 3'd4 - used;
    return diff[1:0];
  endfunction

  // Bit i enables bits [8i+7:8i]; byte 0 of the word is lane 3.
  function automatic logic [3:0] store_mask(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] full;
    case (store_bytes(size))
      3'd1:    full = 4'b0001;
      3'd2:    full = 4'b0011;
      3'd3:    full = 4'b0111;
      default: full = 4'b1111;
    endcase
    return full << store_shift(off, size);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word, input logic [31:0] data,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] aligned;
    logic [3:0]  mask;
    logic [31:0] merged;
    aligned = data << {store_shift(off, size), 3'b000};
    mask    = store_mask(off, size);
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = mask[b] ? aligned[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/data/valid/dirty storage for the data cache: one combinational read port and
// one write port with per-byte enables. Only valid and dirty bits are reset.
module dcache_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int IDX_BITS  = 5,
  parameter int TAG_BITS  = 22
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [IDX_BITS-1:0]    rd_index,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [LINE_BITS-1:0]   rd_data,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  input  logic                   wr_en,
  input  logic [IDX_BITS-1:0]    wr_index,
  input  logic                   wr_tag_en,
  input  logic [TAG_BITS-1:0]    wr_tag,
  input  logic [LINE_BITS-1:0]   wr_data,
  input  logic [LINE_BITS/8-1:0] wr_be,
  input  logic                   wr_valid,
  input  logic                   wr_dirty
);

  logic [TAG_BITS-1:0]  tag_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_index] <= wr_valid;
      dirty_reg[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en && wr_tag_en) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  // Each byte lane is its own narrow RAM so partial stores need no read-modify-write.
  for (genvar gi = 0; gi < LINE_BITS / 8; gi++) begin : g_lane
    logic [7:0] lane_mem [NUM_LINES];

    always_ff @(posedge CLK) begin
      if (wr_en && wr_be[gi]) begin
        lane_mem[wr_index] <= wr_data[8*gi +: 8];
      end
    end

    assign rd_data[8*gi +: 8] = lane_mem[rd_index];
  end

  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_reg[rd_index];
  assign rd_dirty = dirty_reg[rd_index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back data cache with zero-latency hits, block refill/writeback
// handshakes and a flush sequence that writes back then invalidates every line.
module dcache
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 read_2DC,
  input  logic                 write_2DC,
  input  logic [31:0]          data_address_2DC,
  input  logic [31:0]          data_write_2DC,
  input  logic [1:0]           data_write_size_2DC,
  input  logic                 flush_2DC,
  output logic [31:0]          data_read_fDC,
  output logic                 data_valid_fDC,
  output logic                 flush_done,
  output logic [31:0]          data_address_2DM,
  output logic                 dBlkRead,
  output logic                 dBlkWrite,
  output logic [LINE_BITS-1:0] block_write_2DM,
  input  logic [LINE_BITS-1:0] block_read_fDM,
  input  logic                 block_read_fDM_valid,
  input  logic                 block_write_fDM_valid
);

  localparam int IDX_BITS = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_LINES - 1);

  state_t                state_reg, state_next;
  logic [IDX_BITS-1:0]   idx_reg, idx_next;
  logic [TAG_BITS-1:0]   req_tag_reg, req_tag_next;

  logic [IDX_BITS-1:0]   req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [2:0]            word_sel;
  logic [1:0]            byte_off;
  logic [IDX_BITS-1:0]   rd_index;
  logic [TAG_BITS-1:0]   line_tag;
  logic [LINE_BITS-1:0]  line_data;
  logic                  line_valid;
  logic                  line_dirty;
  logic [31:0]           line_word;
  logic [31:0]           store_word;
  logic                  request;
  logic                  hit;

  logic                  wr_en;
  logic                  wr_tag_en;
  logic [IDX_BITS-1:0]   wr_index;
  logic [TAG_BITS-1:0]   wr_tag;
  logic [LINE_BITS-1:0]  wr_data;
  logic [LINE_BITS/8-1:0] wr_be;
  logic                  wr_valid;
  logic                  wr_dirty;

  assign req_index = data_address_2DC[OFFSET_BITS +: IDX_BITS];
  assign req_tag   = data_address_2DC[31 -: TAG_BITS];
  assign word_sel  = data_address_2DC[4:2];
  assign byte_off  = data_address_2DC[1:0];
  assign request   = read_2DC | write_2DC;

  // Outside IDLE the latched index (miss or flush counter) owns the read port.
  assign rd_index  = (state_reg == ST_IDLE) ? req_index : idx_reg;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_BITS  (IDX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .CLK       (CLK),
    .RESET     (RESET),
    .rd_index  (rd_index),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .wr_en     (wr_en),
    .wr_index  (wr_index),
    .wr_tag_en (wr_tag_en),
    .wr_tag    (wr_tag),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .wr_valid  (wr_valid),
    .wr_dirty  (wr_dirty)
  );

  assign line_word  = line_data[{word_sel, 5'b00000} +: 32];
  assign store_word = byte_merge(line_word, data_write_2DC, byte_off, data_write_size_2DC);
  assign hit = RESET && (state_reg == ST_IDLE) && request && !flush_2DC &&
               line_valid && (line_tag == req_tag);

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    req_tag_next = req_tag_reg;
    wr_en        = 1'b0;
    wr_tag_en    = 1'b0;
    wr_index     = idx_reg;
    wr_tag       = req_tag_reg;
    wr_data      = block_read_fDM;
    wr_be        = '0;
    wr_valid     = 1'b0;
    wr_dirty     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (flush_2DC) begin
          idx_next   = '0;
          state_next = ST_FL_SCAN;
        end else if (hit && write_2DC) begin
          wr_en    = 1'b1;
          wr_index = req_index;
          wr_data  = {WORDS_PER_LINE{store_word}};
          wr_be    = {28'd0, store_mask(byte_off, data_write_size_2DC)} << {word_sel, 2'b00};
          wr_valid = 1'b1;
          wr_dirty = 1'b1;
        end else if (request && !hit) begin
          idx_next     = req_index;
          req_tag_next = req_tag;
          state_next   = (line_valid && line_dirty) ? ST_WB : ST_REFILL;
        end
      end
      ST_WB: begin
        if (block_write_fDM_valid) begin
          wr_en      = 1'b1;
          wr_valid   = 1'b1;
          state_next = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (block_read_fDM_valid) begin
          wr_en      = 1'b1;
          wr_tag_en  = 1'b1;
          wr_be      = '1;
          wr_valid   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_FL_SCAN: begin
        if (line_valid && line_dirty) begin
          state_next = ST_FL_WB;
        end else begin
          wr_en = 1'b1;
          if (idx_reg == LAST_IDX) state_next = ST_FL_DONE;
          else                     idx_next   = idx_reg + 1'b1;
        end
      end
      ST_FL_WB: begin
        if (block_write_fDM_valid) begin
          wr_en = 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = ST_FL_DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_FL_SCAN;
          end
        end
      end
      ST_FL_DONE: begin
        idx_next   = '0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A transfer cut short by reset must leave the arrays untouched.
    if (!RESET) wr_en = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      req_tag_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      req_tag_reg <= req_tag_next;
    end
  end

  always_comb begin
    data_valid_fDC   = hit;
    data_read_fDC    = hit ? line_word : 32'd0;
    dBlkWrite        = RESET && ((state_reg == ST_WB) || (state_reg == ST_FL_WB));
    dBlkRead         = RESET && (state_reg == ST_REFILL);
    flush_done       = RESET && (state_reg == ST_FL_DONE);
    block_write_2DM  = dBlkWrite ? line_data : '0;
    data_address_2DM = 32'd0;
    if (dBlkWrite)     data_address_2DM = {line_tag, idx_reg, 5'b00000};
    else if (dBlkRead) data_address_2DM = {req_tag_reg, idx_reg, 5'b00000};
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a table of load/store vectors against a latency-3 block
// memory, plus hand-written flush and reset-during-refill sequences.
module tb_dcache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         read_2DC, write_2DC, flush_2DC;
  logic [31:0]  data_address_2DC, data_write_2DC;
  logic [1:0]   data_write_size_2DC;
  logic [31:0]  data_read_fDC, data_address_2DM;
  logic         data_valid_fDC, flush_done, dBlkRead, dBlkWrite;
  logic [255:0] block_write_2DM, block_read_fDM;
  logic         block_read_fDM_valid, block_write_fDM_valid;

  dcache #(.NUM_LINES(32)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .read_2DC              (read_2DC),
    .write_2DC             (write_2DC),
    .data_address_2DC      (data_address_2DC),
    .data_write_2DC        (data_write_2DC),
    .data_write_size_2DC   (data_write_size_2DC),
    .flush_2DC             (flush_2DC),
    .data_read_fDC         (data_read_fDC),
    .data_valid_fDC        (data_valid_fDC),
    .flush_done            (flush_done),
    .data_address_2DM      (data_address_2DM),
    .dBlkRead              (dBlkRead),
    .dBlkWrite             (dBlkWrite),
    .block_write_2DM       (block_write_2DM),
    .block_read_fDM        (block_read_fDM),
    .block_read_fDM_valid  (block_read_fDM_valid),
    .block_write_fDM_valid (block_write_fDM_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         wr;
    logic [255:0] blk;
    logic [31:0]  addr;
  } ev_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        chk_data;
    logic [31:0] exp_data;
    int          exp_rd;
    int          exp_wr;
    int          exp_cyc;
  } vec_t;

  int           checks = 0;
  int           failures = 0;
  ev_t          ev_q[$];
  logic [255:0] mem [logic [31:0]];
  logic         mem_enable = 1'b1;
  int           lat_cnt = 0;
  vec_t         vecs[14];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mem_get(input logic [31:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return {8{addr}};
  endfunction

  // Block memory: answers a refill or writeback after three waiting cycles.
  initial begin
    block_read_fDM_valid  = 1'b0;
    block_write_fDM_valid = 1'b0;
    block_read_fDM        = '0;
    forever begin
      @(negedge CLK);
      block_read_fDM_valid  = 1'b0;
      block_write_fDM_valid = 1'b0;
      if (dBlkRead || dBlkWrite) check("blk_exclusive", {255'd0, dBlkRead & dBlkWrite}, 256'd0);
      if (mem_enable && (dBlkRead || dBlkWrite)) begin
        if (lat_cnt == 3) begin
          lat_cnt = 0;
          if (dBlkRead) begin
            block_read_fDM       = mem_get(data_address_2DM);
            block_read_fDM_valid = 1'b1;
            ev_q.push_back('{wr: 1'b0, blk: block_read_fDM, addr: data_address_2DM});
          end else begin
            mem[data_address_2DM] = block_write_2DM;
            block_write_fDM_valid = 1'b1;
            ev_q.push_back('{wr: 1'b1, blk: block_write_2DM, addr: data_address_2DM});
          end
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic do_access(input vec_t v, output logic [31:0] rdata, output int cyc, output logic ok);
    @(negedge CLK);
    read_2DC            = !v.wr;
    write_2DC           = v.wr;
    data_address_2DC    = v.addr;
    data_write_2DC      = v.wdata;
    data_write_size_2DC = v.size;
    ok    = 1'b0;
    rdata = 32'd0;
    cyc   = 0;
    while (cyc < 300) begin
      #1;
      if (data_valid_fDC) begin
        rdata = data_read_fDC;
        ok    = 1'b1;
        break;
      end
      @(negedge CLK);
      cyc++;
    end
    @(posedge CLK);
    #1;
    read_2DC  = 1'b0;
    write_2DC = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] blk;
    logic [31:0]  rd;
    logic         ok;
    int           cyc, base, nrd, nwr, done_cnt, done_ev;

    vecs[0]  = '{1'b0, 32'h0000_1000, 32'h0,          2'd0, 1'b1, 32'hDEADBEEF, 1, 0, 5};
    vecs[1]  = '{1'b1, 32'h0000_1001, 32'h0000_00AA,  2'd1, 1'b0, 32'h0,        0, 0, 0};
    vecs[2]  = '{1'b0, 32'h0000_1000, 32'h0,          2'd0, 1'b1, 32'hDEAABEEF, 0, 0, 0};
    vecs[3]  = '{1'b1, 32'h0000_1004, 32'h1234_5678,  2'd0, 1'b0, 32'h0,        0, 0, 0};
    vecs[4]  = '{1'b0, 32'h0000_1004, 32'h0,          2'd0, 1'b1, 32'h12345678, 0, 0, 0};
    vecs[5]  = '{1'b0, 32'h0000_1008, 32'h0,          2'd0, 1'b1, 32'h22222222, 0, 0, 0};
    vecs[6]  = '{1'b1, 32'h0000_1016, 32'h0000_BEEF,  2'd2, 1'b0, 32'h0,        0, 0, 0};
    vecs[7]  = '{1'b0, 32'h0000_1014, 32'h0,          2'd0, 1'b1, 32'h5555BEEF, 0, 0, 0};
    vecs[8]  = '{1'b1, 32'h0000_1019, 32'h00AB_CDEF,  2'd3, 1'b0, 32'h0,        0, 0, 0};
    vecs[9]  = '{1'b0, 32'h0000_1018, 32'h0,          2'd0, 1'b1, 32'h66ABCDEF, 0, 0, 0};
    vecs[10] = '{1'b0, 32'h0000_2000, 32'h0,          2'd0, 1'b1, 32'hA0000000, 1, 1, 9};
    vecs[11] = '{1'b0, 32'h0000_1000, 32'h0,          2'd0, 1'b1, 32'hDEAABEEF, 1, 0, 5};
    vecs[12] = '{1'b1, 32'h0000_10A0, 32'hCAFE_F00D,  2'd0, 1'b0, 32'h0,        1, 0, 5};
    vecs[13] = '{1'b1, 32'h0000_1000, 32'h0BAD_F00D,  2'd0, 1'b0, 32'h0,        0, 0, 0};

    for (int w = 0; w < 8; w++) blk[32*w +: 32] = {8{4'(w)}};
    blk[31:0] = 32'hDEADBEEF;
    mem[32'h0000_1000] = blk;
    for (int w = 0; w < 8; w++) blk[32*w +: 32] = 32'hA000_0000 + 32'(w);
    mem[32'h0000_2000] = blk;

    // Reset with a request already present: every output stays quiet.
    RESET = 1'b0; read_2DC = 1'b1; write_2DC = 1'b0; flush_2DC = 1'b0;
    data_address_2DC = 32'h0000_1000; data_write_2DC = 32'd0; data_write_size_2DC = 2'd0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_dBlkRead",  {255'd0, dBlkRead},       256'd0);
    check("rst_dBlkWrite", {255'd0, dBlkWrite},      256'd0);
    check("rst_valid",     {255'd0, data_valid_fDC}, 256'd0);
    check("rst_flushdone", {255'd0, flush_done},     256'd0);
    check("rst_addr2DM",   {224'd0, data_address_2DM}, 256'd0);
    check("rst_rdata",     {224'd0, data_read_fDC},  256'd0);
    @(negedge CLK);
    RESET = 1'b1; read_2DC = 1'b0;
    #1;
    check("idle_valid", {255'd0, data_valid_fDC}, 256'd0);

    for (int i = 0; i < 14; i++) begin
      base = ev_q.size();
      do_access(vecs[i], rd, cyc, ok);
      nrd = 0; nwr = 0;
      for (int k = base; k < ev_q.size(); k++) begin
        if (ev_q[k].wr) nwr++;
        else            nrd++;
      end
      $display("vec %0d %s addr=%h wdata=%h size=%0d rdata=%h cycles=%0d reads=%0d writes=%0d",
               i, vecs[i].wr ? "ST" : "LD", vecs[i].addr, vecs[i].wdata, vecs[i].size, rd, cyc, nrd, nwr);
      check($sformatf("v%0d_done", i), {255'd0, ok}, 256'd1);
      check($sformatf("v%0d_cycles", i), 256'(cyc), 256'(vecs[i].exp_cyc));
      check($sformatf("v%0d_reads", i), 256'(nrd), 256'(vecs[i].exp_rd));
      check($sformatf("v%0d_writes", i), 256'(nwr), 256'(vecs[i].exp_wr));
      if (vecs[i].chk_data) check($sformatf("v%0d_data", i), {224'd0, rd}, {224'd0, vecs[i].exp_data});
    end

    // Events so far: refill 0x1000, writeback 0x1000, refill 0x2000, refill 0x1000, refill 0x10A0.
    check("ev_count", 256'(ev_q.size()), 256'd5);
    if (ev_q.size() >= 3) begin
      check("refill0_addr", {224'd0, ev_q[0].addr}, {224'd0, 32'h0000_1000});
      check("wb_kind",      {255'd0, ev_q[1].wr},   256'd1);
      check("wb_addr",      {224'd0, ev_q[1].addr}, {224'd0, 32'h0000_1000});
      check("wb_word0",     {224'd0, ev_q[1].blk[31:0]},    {224'd0, 32'hDEAABEEF});
      check("wb_word1",     {224'd0, ev_q[1].blk[63:32]},   {224'd0, 32'h12345678});
      check("wb_word5",     {224'd0, ev_q[1].blk[191:160]}, {224'd0, 32'h5555BEEF});
      check("wb_then_refill_addr", {224'd0, ev_q[2].addr}, {224'd0, 32'h0000_2000});
      check("wb_then_refill_kind", {255'd0, ev_q[2].wr},   256'd0);
    end

    // Flush with a simultaneous hitting load: flush wins, load is serviced afterwards.
    @(negedge CLK);
    flush_2DC = 1'b1; read_2DC = 1'b1; data_address_2DC = 32'h0000_1000;
    #1;
    check("flush_prio_valid", {255'd0, data_valid_fDC}, 256'd0);
    base = ev_q.size(); done_cnt = 0; done_ev = -1; ok = 1'b0; rd = 32'd0;
    @(posedge CLK);
    #1;
    flush_2DC = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      #1;
      if (flush_done) begin
        done_cnt++;
        done_ev = ev_q.size() - base;
        check("flush_done_valid", {255'd0, data_valid_fDC}, 256'd0);
      end
      if (data_valid_fDC) begin
        rd = data_read_fDC;
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    read_2DC = 1'b0;
    $display("flush done_pulses=%0d writes_before_done=%0d events=%0d rdata=%h",
             done_cnt, done_ev, ev_q.size() - base, rd);
    check("flush_complete", {255'd0, ok}, 256'd1);
    check("flush_pulses", 256'(done_cnt), 256'd1);
    check("flush_wb_before_done", 256'(done_ev), 256'd2);
    check("flush_events", 256'(ev_q.size() - base), 256'd3);
    if (ev_q.size() >= base + 3) begin
      check("flush_wb0_kind",  {255'd0, ev_q[base].wr},   256'd1);
      check("flush_wb0_addr",  {224'd0, ev_q[base].addr}, {224'd0, 32'h0000_1000});
      check("flush_wb0_word0", {224'd0, ev_q[base].blk[31:0]}, {224'd0, 32'h0BADF00D});
      check("flush_wb1_kind",  {255'd0, ev_q[base+1].wr},   256'd1);
      check("flush_wb1_addr",  {224'd0, ev_q[base+1].addr}, {224'd0, 32'h0000_10A0});
      check("flush_wb1_word0", {224'd0, ev_q[base+1].blk[31:0]},  {224'd0, 32'hCAFEF00D});
      check("flush_wb1_word1", {224'd0, ev_q[base+1].blk[63:32]}, {224'd0, 32'h000010A0});
      check("post_flush_miss_kind", {255'd0, ev_q[base+2].wr},   256'd0);
      check("post_flush_miss_addr", {224'd0, ev_q[base+2].addr}, {224'd0, 32'h0000_1000});
    end
    check("post_flush_rdata", {224'd0, rd}, {224'd0, 32'h0BADF00D});

    // Reset while a refill waits on memory.
    mem_enable = 1'b0;
    @(negedge CLK);
    read_2DC = 1'b1; data_address_2DC = 32'h0000_3000;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (dBlkRead) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("rr_refill_seen", {255'd0, ok}, 256'd1);
    check("rr_refill_addr", {224'd0, data_address_2DM}, {224'd0, 32'h0000_3000});
    RESET = 1'b0;
    @(negedge CLK);
    #1;
    $display("reset mid-refill dBlkRead=%0d addr=%h valid=%0d", dBlkRead, data_address_2DM, data_valid_fDC);
    check("rr_dBlkRead", {255'd0, dBlkRead}, 256'd0);
    check("rr_addr2DM",  {224'd0, data_address_2DM}, 256'd0);
    check("rr_valid",    {255'd0, data_valid_fDC}, 256'd0);
    RESET = 1'b1; read_2DC = 1'b0; mem_enable = 1'b1;

    base = ev_q.size();
    do_access('{1'b0, 32'h0000_3000, 32'h0, 2'd0, 1'b1, 32'h00003000, 1, 0, 5}, rd, cyc, ok);
    $display("reload addr=00003000 rdata=%h cycles=%0d events=%0d", rd, cyc, ev_q.size() - base);
    check("rr_reload_done",   {255'd0, ok}, 256'd1);
    check("rr_reload_miss",   256'(ev_q.size() - base), 256'd1);
    check("rr_reload_cycles", 256'(cyc), 256'd5);
    check("rr_reload_data",   {224'd0, rd}, {224'd0, 32'h00003000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
